// File: rtl/arb8_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
package arb8_pkg;

    localparam int N_REQ  = 8;
    localparam int ID_W   = 3;
    // Wide enough for any practical MAX_HOLD; the counter saturates at all-ones.
    localparam int HOLD_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/arb8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface arb8_if
    import arb8_pkg::*;
;
    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;
    logic             timeout;

    modport master (output en, req, input gnt, gnt_id, gnt_valid, timeout);
    modport slave  (input en, req, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/arb8_rr_pick8.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping 7->0.
module rr_pick8
    import arb8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  win_id,
    output logic             any
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [ID_W-1:0]    idx;

    // Rotate so ptr lands at bit 0, take the lowest set bit, rotate the index back.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) idx = ID_W'(i);
        end
        win_id = idx + ptr;
        any    = |req;
    end

endmodule

// File: rtl/arb8_ctrl.sv
// 8-requester round-robin arbiter with hold-time limit and registered grant.
module arb8_ctrl
    import arb8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    arb8_if.slave bus
);

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ID_W-1:0]   win_id;
    logic              any;
    logic              drop;
    logic              hold_hit;

    rr_pick8 u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .win_id (win_id),
        .any    (any)
    );

    // Owner lost its request or the arbiter was disabled; this outranks the hold limit.
    assign drop     = !bus.en || !bus.req[bus.gnt_id];
    assign hold_hit = (MAX_HOLD != 0) && (hold_cnt >= HOLD_W'(MAX_HOLD));

    // FSM, pointer, hold counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            hold_cnt      <= '0;
            bus.gnt       <= '0;
            bus.gnt_id    <= '0;
            bus.gnt_valid <= 1'b0;
            bus.timeout   <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en && any) begin
                        state         <= BUSY;
                        bus.gnt       <= onehot(win_id);
                        bus.gnt_id    <= win_id;
                        bus.gnt_valid <= 1'b1;
                        // First visible grant cycle counts as one.
                        hold_cnt      <= HOLD_W'(1);
                    end
                end
                BUSY: begin
                    if (drop || hold_hit) begin
                        state         <= IDLE;
                        bus.gnt       <= '0;
                        bus.gnt_id    <= '0;
                        bus.gnt_valid <= 1'b0;
                        // Next search starts past the owner, so a timed-out owner goes last.
                        ptr           <= bus.gnt_id + ID_W'(1);
                        hold_cnt      <= '0;
                        bus.timeout   <= !drop;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb8_ctrl.sv
// Directed bench for arb8_ctrl (MAX_HOLD=4) plus an exhaustive rr_pick8 sweep.
module tb_arb8_ctrl;
    import arb8_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    arb8_if bus ();

    arb8_ctrl #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] pk_req;
    logic [2:0] pk_ptr;
    logic [2:0] pk_id;
    logic       pk_any;

    rr_pick8 u_pick (
        .req    (pk_req),
        .ptr    (pk_ptr),
        .win_id (pk_id),
        .any    (pk_any)
    );

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       v;
        logic       to;
    } vec_t;

    vec_t tbl [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] g, input logic [2:0] id,
                       input logic v, input logic to);
        checks++;
        if (bus.gnt !== g || bus.gnt_id !== id || bus.gnt_valid !== v || bus.timeout !== to) begin
            errors++;
            $display("FAIL %s: got gnt=%h id=%0d valid=%b to=%b, want gnt=%h id=%0d valid=%b to=%b",
                     nm, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout, g, id, v, to);
        end
    endtask

    task automatic do_reset();
        bus.en  = 1'b0;
        bus.req = 8'h00;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
    endtask

    // gnt must track one-hot(gnt_id) while valid and be zero otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (bus.gnt_valid ? (bus.gnt !== (8'd1 << bus.gnt_id)) : (bus.gnt !== 8'h00)) begin
                errors++;
                $display("FAIL onehot_inv: got gnt=%h id=%0d valid=%b", bus.gnt, bus.gnt_id, bus.gnt_valid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expired, want $finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] e;
        logic [2:0] m_id;
        logic       m_any;
        logic [2:0] c;

        //                en    req    gnt    id    v     to
        tbl[0]  = '{1'b1, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0};  // first grant favours req[0]
        tbl[1]  = '{1'b1, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0};  // hold
        tbl[2]  = '{1'b1, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0};  // owner drops -> release
        tbl[3]  = '{1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0};  // after idle cycle, id 7
        tbl[4]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};  // release, ptr wraps to 0
        tbl[5]  = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};  // disabled: nothing granted
        tbl[6]  = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0};  // enable: grant 0
        tbl[8]  = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};  // en falls in BUSY, no timeout
        tbl[9]  = '{1'b1, 8'hFF, 8'h02, 3'd1, 1'b1, 1'b0};  // ptr advanced past 0
        tbl[10] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            bus.en  = tbl[i].en;
            bus.req = tbl[i].req;
            tick();
            chk($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].v, tbl[i].to);
        end

        // Full rotation, each grant released after two visible cycles.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            e = 3'(k % 8);
            tick(); chk("rr_grant", 8'd1 << e, e, 1'b1, 1'b0);
            tick(); chk("rr_hold", 8'd1 << e, e, 1'b1, 1'b0);
            bus.req = 8'hFF & ~(8'd1 << e);
            tick(); chk("rr_release", 8'h00, 3'd0, 1'b0, 1'b0);
            bus.req = 8'hFF;
        end

        // Hold limit: 4 cycles, timeout pulse, other requester next, then back.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'h06;
        tick(); chk("to_grant1", 8'h02, 3'd1, 1'b1, 1'b0);
        repeat (3) begin tick(); chk("to_hold1", 8'h02, 3'd1, 1'b1, 1'b0); end
        tick(); chk("to_pulse1", 8'h00, 3'd0, 1'b0, 1'b1);
        tick(); chk("to_grant2", 8'h04, 3'd2, 1'b1, 1'b0);
        repeat (3) begin tick(); chk("to_hold2", 8'h04, 3'd2, 1'b1, 1'b0); end
        tick(); chk("to_pulse2", 8'h00, 3'd0, 1'b0, 1'b1);
        tick(); chk("to_wrap", 8'h02, 3'd1, 1'b1, 1'b0);

        // Drop coincides with reaching the limit: drop wins, no pulse.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'h01;
        tick(); chk("dm_grant", 8'h01, 3'd0, 1'b1, 1'b0);
        repeat (3) begin tick(); chk("dm_hold", 8'h01, 3'd0, 1'b1, 1'b0); end
        bus.req = 8'h00;
        tick(); chk("dm_drop", 8'h00, 3'd0, 1'b0, 1'b0);

        // Reset mid-grant clears outputs at once; next grant favours req[0].
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'h20;
        tick(); chk("mr_grant5", 8'h20, 3'd5, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1 chk("mr_async", 8'h00, 3'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        bus.req = 8'h21;
        tick(); chk("mr_regrant", 8'h01, 3'd0, 1'b1, 1'b0);

        // Exhaustive pick sweep against a linear search from ptr.
        for (int p = 0; p < 8; p++) begin
            for (int r = 0; r < 256; r++) begin
                pk_ptr = 3'(p);
                pk_req = 8'(r);
                m_any  = (r != 0);
                m_id   = 3'(p);
                for (int k = 7; k >= 0; k--) begin
                    c = 3'(p + k);
                    if (pk_req[c]) m_id = c;
                end
                #1;
                checks++;
                if (pk_any !== m_any || (m_any && pk_id !== m_id)) begin
                    errors++;
                    $display("FAIL pick ptr=%0d req=%h: got id=%0d any=%b, want id=%0d any=%b",
                             p, r, pk_id, pk_any, m_id, m_any);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
